// File: rtl/load_exec_unit.sv
// ---------------------------------------------------------------------------
// load_exec_unit
//
// Load execution stage that sits after the address-calculation FU. It accepts
// one load (effective address + funct3 type + dest tag + ROB index), issues a
// single word-aligned request to the D-memory port, waits for the response,
// extracts and sign/zero-extends the addressed byte/half/word, and offers the
// result to the complete stage over valid/ready. Only one load is in flight.
// A squash kills the held load; a response that is already owed by memory is
// drained and discarded before new work is accepted.
//
// Optional feature macro: LOAD_MISALIGN_TRAP_EN
//   defined   : misaligned LH/LHU/LW skip memory and complete with data 0 and
//               out_misaligned=1.
//   undefined : out_misaligned is always 0; misalignment is ignored
//               (LW returns the aligned word, LH/LHU use addr[1] only).
//
// Ports
//   clock, reset                  posedge clock, synchronous active-high reset
//   in_valid/in_ready             load handoff from the address FU
//   in_addr/in_funct3             effective address, load type
//   in_dest_tag/in_rob_idx        bookkeeping carried through to the result
//   squash                        flush; kills the held load
//   mem_req_valid/ready/addr      word-aligned D-memory request
//   mem_resp_valid/data           D-memory response word
//   out_valid/out_ready           result handoff to the complete stage
//   out_data/out_dest_tag/
//   out_rob_idx/out_misaligned    result payload
// ---------------------------------------------------------------------------
module load_exec_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6,
  parameter int ROB_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_addr,
  input  logic [2:0]       in_funct3,
  input  logic [TAG_W-1:0] in_dest_tag,
  input  logic [ROB_W-1:0] in_rob_idx,
  input  logic             squash,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [XLEN-1:0]  mem_req_addr,
  input  logic             mem_resp_valid,
  input  logic [XLEN-1:0]  mem_resp_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_dest_tag,
  output logic [ROB_W-1:0] out_rob_idx,
  output logic             out_misaligned
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [ROB_W-1:0] rob_q, rob_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic             mis_q, mis_d;

  logic accept;
  logic mis_trap;

  // Byte/half selection by shifting the word down; anything that is not a
  // byte or half type (including the unused encodings 3/6/7) returns the word.
  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] word,
                                              input logic [1:0]      off,
                                              input logic [2:0]      f3);
    logic [XLEN-1:0] sh_b;
    logic [XLEN-1:0] sh_h;
    sh_b = word >> {off, 3'b000};
    sh_h = word >> {off[1], 4'b0000};
    case (f3)
      3'd0:    extract = {{(XLEN-8){sh_b[7]}}, sh_b[7:0]};
      3'd1:    extract = {{(XLEN-16){sh_h[15]}}, sh_h[15:0]};
      3'd4:    extract = {{(XLEN-8){1'b0}}, sh_b[7:0]};
      3'd5:    extract = {{(XLEN-16){1'b0}}, sh_h[15:0]};
      default: extract = word;
    endcase
  endfunction

`ifdef LOAD_MISALIGN_TRAP_EN
  // Halves need addr[0]=0; words (LW and the encodings treated as LW) need
  // addr[1:0]=0. Bytes can never be misaligned.
  always_comb begin
    case (in_funct3)
      3'd0, 3'd4: mis_trap = 1'b0;
      3'd1, 3'd5: mis_trap = in_addr[0];
      default:    mis_trap = |in_addr[1:0];
    endcase
  end
`else
  assign mis_trap = 1'b0;
`endif

  // Reset is folded into in_ready so nothing is accepted on a reset edge.
  assign in_ready = (state_q == S_IDLE) & ~squash & ~reset;
  assign accept   = in_valid & in_ready;

  assign mem_req_valid  = (state_q == S_REQ);
  assign mem_req_addr   = {addr_q[XLEN-1:2], 2'b00};
  assign out_valid      = (state_q == S_DONE);
  assign out_data       = data_q;
  assign out_dest_tag   = tag_q;
  assign out_rob_idx    = rob_q;
  assign out_misaligned = mis_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    tag_d    = tag_q;
    rob_d    = rob_q;
    data_d   = data_q;
    mis_d    = mis_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d   = in_addr;
          funct3_d = in_funct3;
          tag_d    = in_dest_tag;
          rob_d    = in_rob_idx;
          mis_d    = mis_trap;
          if (mis_trap) begin
            data_d  = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end

      S_REQ: begin
        // A request that handshakes on the squash cycle still owes a response.
        if (squash)             state_d = mem_req_ready ? S_DRAIN : S_IDLE;
        else if (mem_req_ready) state_d = S_WAIT;
      end

      S_WAIT: begin
        if (squash) begin
          state_d = mem_resp_valid ? S_IDLE : S_DRAIN;
        end else if (mem_resp_valid) begin
          data_d  = extract(mem_resp_data, addr_q[1:0], funct3_q);
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (squash || out_ready) state_d = S_IDLE;
      end

      S_DRAIN: begin
        // The owed response clears the drain whether or not another squash
        // arrives with it; a squash alone keeps waiting for that response.
        if (mem_resp_valid) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: the payload registers are few and visible on the outputs, so all
    // of them are cleared on reset rather than only the state register.
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      tag_q    <= '0;
      rob_q    <= '0;
      data_q   <= '0;
      mis_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      tag_q    <= tag_d;
      rob_q    <= rob_d;
      data_q   <= data_d;
      mis_q    <= mis_d;
    end
  end

endmodule
